stepper_seq: RTL and testbench

STEPPER_SEQ -- requirements
Module: stepper_seq

---
 rtl/stepper_pkg.sv | 30 +++
 rtl/stepper_seq_if.sv | 40 ++++
 rtl/stepper_phase_lut.sv | 17 +
 rtl/stepper_seq.sv | 164 ++++++++++++++++
 tb/tb_stepper_seq.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stepper_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stepper_pkg
// Purpose  : Shared types and constants for the stepper sequencer slice:
//            FSM state encoding, coil phase table, default field widths.
// Revision : 1.0 - initial release
// ============================================================================
package stepper_pkg;

  localparam int STEPS_W_DEF = 16;
  localparam int POS_W_DEF   = 16;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_WAIT_ON  = 3'd2,
    S_WAIT_OFF = 3'd3,
    S_ADVANCE  = 3'd4,
    S_DONE     = 3'd5,
    S_FAULT    = 3'd6
  } state_t;

  // Half-step phase table; element [i] is the coil pattern for index i.
  localparam logic [7:0][3:0] C_PHASE_TABLE = {
    4'b1001, 4'b1000, 4'b1100, 4'b0100,
    4'b0110, 4'b0010, 4'b0011, 4'b0001
  };

endpackage
`default_nettype wire

// File: rtl/stepper_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : stepper_seq_if
// Purpose  : Bundles the move-command handshake, the pulse-timer link and the
//            status/drive outputs of the stepper sequencer.
// Ports    : none (signals only)
//   master : command source + pulse timer (drives cmd_*, abort, pulse_on)
//   slave  : the sequencer (drives cmd_ready, pulse_*, coil, pos, status)
// Revision : 1.0 - initial release
// ============================================================================
interface stepper_seq_if #(
  parameter int STEPS_W = 16,
  parameter int POS_W   = 16
) ();
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_dir;
  logic               cmd_half;
  logic [STEPS_W-1:0] cmd_steps;
  logic               abort;
  logic               pulse_start;
  logic               pulse_hs;
  logic               pulse_on;
  logic [3:0]         coil;
  logic [POS_W-1:0]   pos;
  logic               busy;
  logic               done;
  logic               fault;

  modport master (
    output cmd_valid, cmd_dir, cmd_half, cmd_steps, abort, pulse_on,
    input  cmd_ready, pulse_start, pulse_hs, coil, pos, busy, done, fault
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_half, cmd_steps, abort, pulse_on,
    output cmd_ready, pulse_start, pulse_hs, coil, pos, busy, done, fault
  );
endinterface
`default_nettype wire

// File: rtl/stepper_phase_lut.sv
`default_nettype none
// ============================================================================
// Module   : stepper_phase_lut
// Purpose  : Combinational phase index to coil pattern lookup.
// Ports    : i_idx  [2:0] phase index 0..7
//            o_coil [3:0] coil drive pattern for that index
// Revision : 1.0 - initial release
// ============================================================================
module stepper_phase_lut
  import stepper_pkg::*;
(
  input  wire logic [2:0] i_idx,
  output logic      [3:0] o_coil
);
  assign o_coil = C_PHASE_TABLE[i_idx];
endmodule
`default_nettype wire

// File: rtl/stepper_seq.sv
`default_nettype none
// ============================================================================
// Module   : stepper_seq
// Purpose  : Stepper motor move sequencer. Accepts a move command, issues one
//            timer pulse per step, advances the coil phase and the signed
//            half-step position, and faults if the timer never responds.
// Ports    : spd  step-rate clock (posedge)
//            rst  asynchronous active-low reset
//            bus  stepper_seq_if.slave (command, timer link, coil/status)
// Revision : 1.0 - initial release
// ============================================================================
module stepper_seq
  import stepper_pkg::*;
#(
  parameter int STEPS_W    = STEPS_W_DEF,
  parameter int POS_W      = POS_W_DEF,
  parameter int ON_TIMEOUT = 7
) (
  input  wire logic    spd,
  input  wire logic    rst,
  stepper_seq_if.slave bus
);

  localparam int TO_W = (ON_TIMEOUT > 1) ? $clog2(ON_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] C_TO_LAST = TO_W'(ON_TIMEOUT - 1);

  state_t             r_state;
  logic               r_ready;
  logic               r_busy;
  logic               r_start;
  logic               r_done;
  logic               r_fault;
  logic               r_dir;
  logic               r_half;
  logic               r_abort;
  logic [2:0]         r_idx;
  logic [3:0]         r_coil;
  logic [POS_W-1:0]   r_pos;
  logic [STEPS_W-1:0] r_rem;
  logic [TO_W-1:0]    r_to;

  logic [2:0]         w_step;
  logic [2:0]         w_idx_adv;
  logic [POS_W-1:0]   w_pos_delta;
  logic [POS_W-1:0]   w_pos_adv;
  logic [STEPS_W-1:0] w_rem_dec;
  logic               w_abort_now;
  logic [2:0]         w_lut_idx;
  logic [3:0]         w_coil;

  assign w_step      = r_half ? 3'd1 : 3'd2;
  assign w_idx_adv   = r_dir ? (r_idx + w_step) : (r_idx - w_step);
  assign w_pos_delta = r_half ? POS_W'(1) : POS_W'(2);
  assign w_pos_adv   = r_dir ? (r_pos + w_pos_delta) : (r_pos - w_pos_delta);
  assign w_rem_dec   = r_rem - STEPS_W'(1);
  // An abort arriving in the ADVANCE cycle itself still ends the move now.
  assign w_abort_now = r_abort | bus.abort;
  // Look up the index being written so coil and index change together.
  assign w_lut_idx   = (r_state == S_ADVANCE) ? w_idx_adv : r_idx;

  stepper_phase_lut u_lut (
    .i_idx  (w_lut_idx),
    .o_coil (w_coil)
  );

  always_ff @(posedge spd or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_start <= 1'b0;
      r_done  <= 1'b0;
      r_fault <= 1'b0;
      r_dir   <= 1'b0;
      r_half  <= 1'b0;
      r_abort <= 1'b0;
      r_idx   <= 3'd0;
      r_coil  <= 4'b0001;
      r_pos   <= '0;
      r_rem   <= '0;
      r_to    <= '0;
    end else begin
      r_start <= 1'b0;
      r_done  <= 1'b0;
      r_coil  <= w_coil;
      if (bus.abort && (r_state != S_IDLE) && (r_state != S_DONE))
        r_abort <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            r_dir   <= bus.cmd_dir;
            r_half  <= bus.cmd_half;
            r_rem   <= bus.cmd_steps;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            if (bus.cmd_steps == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_START;
              r_start <= 1'b1;
            end
          end
        end
        S_START: begin
          r_to    <= '0;
          r_state <= S_WAIT_ON;
        end
        S_WAIT_ON: begin
          if (bus.pulse_on) begin
            r_state <= S_WAIT_OFF;
          end else if (r_to == C_TO_LAST) begin
            r_state <= S_FAULT;
            r_fault <= 1'b1;
          end else begin
            r_to <= r_to + TO_W'(1);
          end
        end
        S_WAIT_OFF: begin
          if (!bus.pulse_on)
            r_state <= S_ADVANCE;
        end
        S_ADVANCE: begin
          r_idx <= w_idx_adv;
          r_pos <= w_pos_adv;
          r_rem <= w_rem_dec;
          if ((w_rem_dec == '0) || w_abort_now) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_START;
            r_start <= 1'b1;
          end
        end
        S_DONE: begin
          r_abort <= 1'b0;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_FAULT: begin
          r_state <= S_FAULT;
        end
        default: begin
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready   = r_ready;
  assign bus.pulse_start = r_start;
  assign bus.pulse_hs    = r_half;
  assign bus.coil        = r_coil;
  assign bus.pos         = r_pos;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.fault       = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_stepper_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_stepper_seq
// Purpose  : Directed self-checking bench for stepper_seq with a simple
//            pulse-timer model (4-cycle on window, or dead).
// Revision : 1.0 - initial release
// ============================================================================
module tb_stepper_seq;

  logic spd = 1'b0;
  logic rst;
  always #5 spd = ~spd;

  stepper_seq_if #(.STEPS_W(16), .POS_W(16)) bus ();

  stepper_seq #(.STEPS_W(16), .POS_W(16), .ON_TIMEOUT(7)) dut (
    .spd (spd),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int n_start, n_done, n_rec, hs_bad;
  int tm_cnt;
  logic tm_dead;
  logic exp_hs;
  logic [3:0] last_coil;
  logic [3:0] rec [16];

  // One cycle: observe at the negedge, then update the timer model.
  task automatic tick();
    @(negedge spd);
    if (bus.pulse_start === 1'b1) n_start++;
    if (bus.done === 1'b1) n_done++;
    if (bus.busy === 1'b1 && bus.pulse_hs !== exp_hs) hs_bad++;
    if (bus.coil !== last_coil) begin
      if (n_rec < 16) rec[n_rec] = bus.coil;
      n_rec++;
      last_coil = bus.coil;
    end
    if (bus.pulse_start === 1'b1 && !tm_dead) tm_cnt = 4;
    if (tm_cnt > 0) begin
      bus.pulse_on = 1'b1;
      tm_cnt--;
    end else begin
      bus.pulse_on = 1'b0;
    end
  endtask

  task automatic clear_obs();
    n_start = 0; n_done = 0; n_rec = 0;
    last_coil = bus.coil;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.cmd_valid = 1'b0; bus.abort = 1'b0;
    tm_cnt = 0; bus.pulse_on = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  // Issue a command (abort optionally raised with it), wait for done, then
  // one extra cycle so a second done pulse would be counted.
  task automatic run_move(input logic dir, input logic half,
                          input logic [15:0] steps, input logic ab,
                          input string name);
    exp_hs = half;
    clear_obs();
    bus.cmd_dir = dir; bus.cmd_half = half; bus.cmd_steps = steps;
    bus.abort = ab; bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0; bus.abort = 1'b0;
    for (int k = 0; k < 200 && n_done == 0; k++) tick();
    checks++;
    if (n_done == 0) begin
      errors++;
      $display("FAIL %s_timeout: no done within 200 cycles", name);
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    checks++;
    if ({bus.coil, bus.pos} !== {4'b0001, 16'h0000}) begin
      errors++;
      $display("FAIL reset_coil_pos: got %b/%h expected 0001/0000", bus.coil, bus.pos);
    end
    checks++;
    if ({bus.cmd_ready, bus.busy, bus.done, bus.fault, bus.pulse_start, bus.pulse_hs} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 100000",
               {bus.cmd_ready, bus.busy, bus.done, bus.fault, bus.pulse_start, bus.pulse_hs});
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_half_fwd();
    run_move(1'b1, 1'b1, 16'd3, 1'b0, "half_fwd");
    checks++;
    if (n_start != 3) begin
      errors++; $display("FAIL half_fwd_starts: got %0d expected 3", n_start);
    end
    checks++;
    if (n_rec != 3 || rec[0] !== 4'b0011 || rec[1] !== 4'b0010 || rec[2] !== 4'b0110) begin
      errors++;
      $display("FAIL half_fwd_coil: got n=%0d %b %b %b expected 3 0011 0010 0110",
               n_rec, rec[0], rec[1], rec[2]);
    end
    checks++;
    if (bus.pos !== 16'd3) begin
      errors++; $display("FAIL half_fwd_pos: got %h expected 0003", bus.pos);
    end
    checks++;
    if (n_done != 1) begin
      errors++; $display("FAIL half_fwd_done: got %0d expected 1", n_done);
    end
    checks++;
    if ({bus.busy, bus.cmd_ready} !== 2'b01) begin
      errors++; $display("FAIL half_fwd_idle: got busy/ready %b expected 01", {bus.busy, bus.cmd_ready});
    end
  endtask

  task automatic test_full_rev();
    do_reset();
    run_move(1'b0, 1'b0, 16'd5, 1'b0, "full_rev");
    checks++;
    if (n_rec != 5 || rec[0] !== 4'b1000 || rec[1] !== 4'b0100 || rec[2] !== 4'b0010 ||
        rec[3] !== 4'b0001 || rec[4] !== 4'b1000) begin
      errors++;
      $display("FAIL full_rev_coil: got n=%0d %b %b %b %b %b expected 5 1000 0100 0010 0001 1000",
               n_rec, rec[0], rec[1], rec[2], rec[3], rec[4]);
    end
    checks++;
    if (bus.pos !== 16'hFFF6) begin
      errors++; $display("FAIL full_rev_pos: got %h expected fff6", bus.pos);
    end
    checks++;
    if (n_start != 5 || n_done != 1) begin
      errors++; $display("FAIL full_rev_counts: got starts=%0d done=%0d expected 5 1", n_start, n_done);
    end
  endtask

  task automatic test_zero_steps();
    exp_hs = 1'b0;
    clear_obs();
    bus.cmd_dir = 1'b1; bus.cmd_half = 1'b0; bus.cmd_steps = 16'd0; bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    checks++;
    if (bus.done !== 1'b1) begin
      errors++; $display("FAIL zero_done: got %b expected 1", bus.done);
    end
    tick();
    checks++;
    if ({bus.done, bus.busy} !== 2'b00) begin
      errors++; $display("FAIL zero_after: got done/busy %b expected 00", {bus.done, bus.busy});
    end
    checks++;
    if (n_start != 0 || bus.pos !== 16'hFFF6) begin
      errors++; $display("FAIL zero_nomove: got starts=%0d pos=%h expected 0 fff6", n_start, bus.pos);
    end
  endtask

  task automatic test_abort();
    exp_hs = 1'b1;
    clear_obs();
    bus.cmd_dir = 1'b1; bus.cmd_half = 1'b1; bus.cmd_steps = 16'd10; bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    for (int k = 0; k < 50 && n_start < 2; k++) tick();
    tick();  // WAIT_ON of step 2
    tick();  // WAIT_OFF of step 2
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    for (int k = 0; k < 100 && n_done == 0; k++) tick();
    tick();
    checks++;
    if (n_start != 2 || n_done != 1) begin
      errors++; $display("FAIL abort_counts: got starts=%0d done=%0d expected 2 1", n_start, n_done);
    end
    checks++;
    if (bus.pos !== 16'hFFF8 || bus.coil !== 4'b0001) begin
      errors++; $display("FAIL abort_pos: got %h/%b expected fff8/0001", bus.pos, bus.coil);
    end
  endtask

  task automatic test_abort_ignored();
    bus.abort = 1'b1;
    tick();
    tick();
    bus.abort = 1'b0;
    run_move(1'b1, 1'b1, 16'd2, 1'b1, "abort_ign");
    checks++;
    if (n_start != 2 || bus.pos !== 16'hFFFA || bus.coil !== 4'b0010) begin
      errors++;
      $display("FAIL abort_ign: got starts=%0d pos=%h coil=%b expected 2 fffa 0010",
               n_start, bus.pos, bus.coil);
    end
  endtask

  task automatic test_fault();
    int k;
    tm_dead = 1'b1;
    exp_hs = 1'b1;
    clear_obs();
    bus.cmd_dir = 1'b1; bus.cmd_half = 1'b1; bus.cmd_steps = 16'd2; bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    for (k = 1; k <= 30; k++) begin
      tick();
      if (bus.fault === 1'b1) break;
    end
    checks++;
    if (k != 8) begin
      errors++; $display("FAIL fault_latency: got %0d cycles expected 8", k);
    end
    tm_dead = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd_steps = 16'd1;
    for (int j = 0; j < 20; j++) tick();
    bus.cmd_valid = 1'b0;
    checks++;
    if ({bus.fault, bus.busy, bus.cmd_ready, bus.pulse_start} !== 4'b1100 || n_start != 1) begin
      errors++;
      $display("FAIL fault_hold: got f/b/r/ps %b starts=%0d expected 1100 1",
               {bus.fault, bus.busy, bus.cmd_ready, bus.pulse_start}, n_start);
    end
    checks++;
    if (bus.coil !== 4'b0010 || bus.pos !== 16'hFFFA) begin
      errors++; $display("FAIL fault_coil: got %b/%h expected 0010/fffa", bus.coil, bus.pos);
    end
    do_reset();
    checks++;
    if ({bus.fault, bus.cmd_ready} !== 2'b01) begin
      errors++; $display("FAIL fault_recover: got fault/ready %b expected 01", {bus.fault, bus.cmd_ready});
    end
  endtask

  task automatic test_reset_mid();
    run_move(1'b1, 1'b1, 16'd1, 1'b0, "pre_mid");
    exp_hs = 1'b1;
    clear_obs();
    bus.cmd_dir = 1'b1; bus.cmd_half = 1'b1; bus.cmd_steps = 16'd4; bus.cmd_valid = 1'b1;
    tick();  // START
    bus.cmd_valid = 1'b0;
    tick();  // WAIT_ON
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.coil, bus.pos} !== {4'b0001, 16'h0000}) begin
      errors++; $display("FAIL mid_reset_coil_pos: got %b/%h expected 0001/0000", bus.coil, bus.pos);
    end
    checks++;
    if ({bus.cmd_ready, bus.busy, bus.done, bus.fault, bus.pulse_start, bus.pulse_hs} !== 6'b100000) begin
      errors++;
      $display("FAIL mid_reset_flags: got %b expected 100000",
               {bus.cmd_ready, bus.busy, bus.done, bus.fault, bus.pulse_start, bus.pulse_hs});
    end
    tm_cnt = 0; bus.pulse_on = 1'b0;
    tick();
    rst = 1'b1;
    n_done = 0; n_start = 0;
    for (int j = 0; j < 10; j++) tick();
    checks++;
    if (n_done != 0 || n_start != 0) begin
      errors++; $display("FAIL mid_reset_quiet: got done=%0d starts=%0d expected 0 0", n_done, n_start);
    end
    run_move(1'b1, 1'b1, 16'd2, 1'b0, "post_mid");
    checks++;
    if (n_start != 2 || n_done != 1 || bus.pos !== 16'd2 || bus.coil !== 4'b0010) begin
      errors++;
      $display("FAIL post_mid: got starts=%0d done=%0d pos=%h coil=%b expected 2 1 0002 0010",
               n_start, n_done, bus.pos, bus.coil);
    end
  endtask

  task automatic test_hs_stable();
    checks++;
    if (hs_bad != 0) begin
      errors++; $display("FAIL pulse_hs_stable: got %0d bad cycles expected 0", hs_bad);
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_dir = 1'b0; bus.cmd_half = 1'b0;
    bus.cmd_steps = '0; bus.abort = 1'b0; bus.pulse_on = 1'b0;
    tm_dead = 1'b0; tm_cnt = 0; exp_hs = 1'b0; hs_bad = 0;
    n_start = 0; n_done = 0; n_rec = 0; last_coil = 4'b0001;
    test_reset();
    test_half_fwd();
    test_full_rev();
    test_zero_steps();
    test_abort();
    test_abort_ignored();
    test_fault();
    test_reset_mid();
    test_hs_stable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
